// File: rtl/bumpy_pkg.sv
// Shared definitions for the step/player drawing blocks.
//   step_type_t          : class of the step drawer that owns a pixel
//   EDGE_*               : one-hot player edge codes carried on HitEdgeCode
//   TRANSPARENT_ENCODING : colour value drawers output for "no pixel"
//   det_state_t          : collision detector frame FSM states
package bumpy_pkg;

  typedef enum logic [2:0] {
    FREE  = 3'd0,
    REGU  = 3'd1,
    GATE  = 3'd2,
    DEATH = 3'd3,
    WALL  = 3'd4,
    SPIKE = 3'd5,
    BRAKE = 3'd6
  } step_type_t;

  localparam logic [3:0] EDGE_NONE   = 4'b0000;
  localparam logic [3:0] EDGE_BOTTOM = 4'b0001;
  localparam logic [3:0] EDGE_RIGHT  = 4'b0010;
  localparam logic [3:0] EDGE_TOP    = 4'b0100;
  localparam logic [3:0] EDGE_LEFT   = 4'b1000;

  localparam logic [7:0] TRANSPARENT_ENCODING = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PUBLISH = 2'd2
  } det_state_t;

  function automatic logic is_brake_class(input logic [2:0] t);
    return t == BRAKE;
  endfunction

  function automatic logic is_regular_class(input logic [2:0] t);
    return (t == REGU) || (t == GATE) || (t == WALL);
  endfunction

  function automatic logic is_death_class(input logic [2:0] t);
    return (t == DEATH) || (t == SPIKE);
  endfunction

endpackage

// File: rtl/edge_classifier.sv
// Combinational classification of a pixel offset inside the player sprite.
// Ports:
//   offset_x, offset_y : pixel offset inside the sprite box
//   edge_code          : one-hot edge (BOTTOM/RIGHT/TOP/LEFT), 0 if none
//   interior           : pixel is inside the box but not on any edge band
// Pixels outside the box report edge_code = 0 and interior = 0.
module edge_classifier
  import bumpy_pkg::*;
#(
  parameter int PLAYER_W   = 32,
  parameter int PLAYER_H   = 32,
  parameter int EDGE_DEPTH = 4
) (
  input  logic [10:0] offset_x,
  input  logic [10:0] offset_y,
  output logic [3:0]  edge_code,
  output logic        interior
);

  localparam logic [10:0] W_LIM   = 11'(PLAYER_W);
  localparam logic [10:0] H_LIM   = 11'(PLAYER_H);
  localparam logic [10:0] DEPTH   = 11'(EDGE_DEPTH);
  localparam logic [10:0] BOT_LIM = 11'(PLAYER_H - EDGE_DEPTH);
  localparam logic [10:0] RGT_LIM = 11'(PLAYER_W - EDGE_DEPTH);

  // Bands are tested in a fixed order so corner pixels land on a single
  // edge: bottom and top take the corners before left and right.
  always_comb begin
    edge_code = EDGE_NONE;
    interior  = 1'b0;
    if ((offset_x < W_LIM) && (offset_y < H_LIM)) begin
      if (offset_y >= BOT_LIM)      edge_code = EDGE_BOTTOM;
      else if (offset_y < DEPTH)    edge_code = EDGE_TOP;
      else if (offset_x < DEPTH)    edge_code = EDGE_LEFT;
      else if (offset_x >= RGT_LIM) edge_code = EDGE_RIGHT;
      else                          interior  = 1'b1;
    end
  end

endmodule

// File: rtl/step_collision_detector.sv
// Per-frame collision detector between the player sprite and step drawers.
// Counts overlap pixels per player edge and per step class during a frame,
// and at each startOfFrame publishes a verdict that stays stable for the
// whole following frame.
// Ports:
//   clk, resetN                : pixel clock, async active-low reset
//   startOfFrame               : one-cycle pulse on the first pixel of a frame
//   player_drawingRequest      : player sprite pixel is opaque
//   player_offsetX/Y           : pixel offset inside the player sprite
//   step_drawingRequest        : some step drawer owns this pixel
//   step_type                  : class of that step (bumpy_pkg::step_type_t)
//   breaking/regular/death_*   : class verdicts for the previous frame
//   HitEdgeCode                : one-hot dominant player edge, 0 = none
//   verdict_valid              : high for the single cycle after publishing
// Handshake: verdict_valid is a one-cycle strobe with no ready; the verdict
// outputs are levels that only change in the cycle verdict_valid is high.
module step_collision_detector
  import bumpy_pkg::*;
#(
  parameter int PLAYER_W   = 32,
  parameter int PLAYER_H   = 32,
  parameter int EDGE_DEPTH = 4,
  parameter int MIN_HITS   = 2,
  parameter int COUNT_W    = 10
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        player_drawingRequest,
  input  logic [10:0] player_offsetX,
  input  logic [10:0] player_offsetY,
  input  logic        step_drawingRequest,
  input  logic [2:0]  step_type,
  output logic        breaking_step_collision,
  output logic        regular_step_collision,
  output logic        death_collision,
  output logic [3:0]  HitEdgeCode,
  output logic        verdict_valid
);

  det_state_t state_q, state_d;

  logic [3:0] edge_code;
  logic       interior;

  logic [COUNT_W-1:0] cnt_bottom_q, cnt_right_q, cnt_top_q, cnt_left_q, cnt_total_q;
  logic [COUNT_W-1:0] cnt_bottom_d, cnt_right_d, cnt_top_d, cnt_left_d, cnt_total_d;
  logic               brk_q, reg_q, dth_q;
  logic               brk_d, reg_d, dth_d;

  logic               hit;
  logic               count_en;
  logic               publish;
  logic               enough;
  logic [3:0]         dom_code;
  logic [COUNT_W-1:0] best_cnt;

  edge_classifier #(
    .PLAYER_W  (PLAYER_W),
    .PLAYER_H  (PLAYER_H),
    .EDGE_DEPTH(EDGE_DEPTH)
  ) u_edge_classifier (
    .offset_x (player_offsetX),
    .offset_y (player_offsetY),
    .edge_code(edge_code),
    .interior (interior)
  );

  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v,
                                                 input logic en);
    if (en && (v != '1)) return v + COUNT_W'(1);
    return v;
  endfunction

  // Out-of-box pixels have neither an edge nor the interior flag, so they
  // drop out of the hit definition here.
  assign hit = player_drawingRequest && step_drawingRequest &&
               (step_type != FREE) && (interior || (|edge_code));

  // Nothing counts before the first frame boundary; the boundary pixel
  // itself already belongs to the new frame.
  assign count_en = hit && ((state_q != ST_IDLE) || startOfFrame);
  assign publish  = startOfFrame && (state_q != ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (startOfFrame) state_d = ST_SCAN;
      ST_SCAN:    if (startOfFrame) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = startOfFrame ? ST_PUBLISH : ST_SCAN;
      default:    state_d = ST_IDLE;
    endcase
  end

  // On a frame boundary the accumulators restart from zero and then take
  // the boundary pixel, so it is neither lost nor counted twice.
  always_comb begin
    cnt_bottom_d = startOfFrame ? '0 : cnt_bottom_q;
    cnt_right_d  = startOfFrame ? '0 : cnt_right_q;
    cnt_top_d    = startOfFrame ? '0 : cnt_top_q;
    cnt_left_d   = startOfFrame ? '0 : cnt_left_q;
    cnt_total_d  = startOfFrame ? '0 : cnt_total_q;
    brk_d        = startOfFrame ? 1'b0 : brk_q;
    reg_d        = startOfFrame ? 1'b0 : reg_q;
    dth_d        = startOfFrame ? 1'b0 : dth_q;

    cnt_bottom_d = sat_inc(cnt_bottom_d, count_en && edge_code[0]);
    cnt_right_d  = sat_inc(cnt_right_d,  count_en && edge_code[1]);
    cnt_top_d    = sat_inc(cnt_top_d,    count_en && edge_code[2]);
    cnt_left_d   = sat_inc(cnt_left_d,   count_en && edge_code[3]);
    cnt_total_d  = sat_inc(cnt_total_d,  count_en);
    brk_d        = brk_d | (count_en && is_brake_class(step_type));
    reg_d        = reg_d | (count_en && is_regular_class(step_type));
    dth_d        = dth_d | (count_en && is_death_class(step_type));
  end

  // Strict '>' keeps the earlier candidate on ties, giving the order
  // BOTTOM > TOP > LEFT > RIGHT; all-zero edges leave BOTTOM selected.
  always_comb begin
    best_cnt = cnt_bottom_q;
    dom_code = EDGE_BOTTOM;
    if (cnt_top_q > best_cnt) begin
      best_cnt = cnt_top_q;
      dom_code = EDGE_TOP;
    end
    if (cnt_left_q > best_cnt) begin
      best_cnt = cnt_left_q;
      dom_code = EDGE_LEFT;
    end
    if (cnt_right_q > best_cnt) begin
      best_cnt = cnt_right_q;
      dom_code = EDGE_RIGHT;
    end
  end

  assign enough = cnt_total_q >= COUNT_W'(MIN_HITS);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q      <= ST_IDLE;
      cnt_bottom_q <= '0;
      cnt_right_q  <= '0;
      cnt_top_q    <= '0;
      cnt_left_q   <= '0;
      cnt_total_q  <= '0;
      brk_q        <= 1'b0;
      reg_q        <= 1'b0;
      dth_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_bottom_q <= cnt_bottom_d;
      cnt_right_q  <= cnt_right_d;
      cnt_top_q    <= cnt_top_d;
      cnt_left_q   <= cnt_left_d;
      cnt_total_q  <= cnt_total_d;
      brk_q        <= brk_d;
      reg_q        <= reg_d;
      dth_q        <= dth_d;
    end
  end

  // Verdict registers load from the pre-clear accumulators on the boundary
  // cycle so the new values appear in the PUBLISH cycle.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      breaking_step_collision <= 1'b0;
      regular_step_collision  <= 1'b0;
      death_collision         <= 1'b0;
      HitEdgeCode             <= EDGE_NONE;
    end else if (publish) begin
      breaking_step_collision <= enough && brk_q;
      regular_step_collision  <= enough && reg_q;
      death_collision         <= enough && dth_q;
      HitEdgeCode             <= enough ? dom_code : EDGE_NONE;
    end
  end

  assign verdict_valid = (state_q == ST_PUBLISH);

endmodule

// File: tb/tb_step_collision_detector.sv
// Directed bench for step_collision_detector: a table of per-frame vectors
// followed by hand-written sequences for frame-boundary, saturation,
// back-to-back startOfFrame and asynchronous reset cases.
module tb_step_collision_detector;

  logic        clk = 1'b0;
  logic        resetN;
  logic        startOfFrame;
  logic        player_drawingRequest;
  logic [10:0] player_offsetX;
  logic [10:0] player_offsetY;
  logic        step_drawingRequest;
  logic [2:0]  step_type;
  logic        breaking_step_collision;
  logic        regular_step_collision;
  logic        death_collision;
  logic [3:0]  HitEdgeCode;
  logic        verdict_valid;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  step_collision_detector dut (
    .clk                    (clk),
    .resetN                 (resetN),
    .startOfFrame           (startOfFrame),
    .player_drawingRequest  (player_drawingRequest),
    .player_offsetX         (player_offsetX),
    .player_offsetY         (player_offsetY),
    .step_drawingRequest    (step_drawingRequest),
    .step_type              (step_type),
    .breaking_step_collision(breaking_step_collision),
    .regular_step_collision (regular_step_collision),
    .death_collision        (death_collision),
    .HitEdgeCode            (HitEdgeCode),
    .verdict_valid          (verdict_valid)
  );

  typedef struct {
    string      name;
    int         ta, xa, ya, na;
    int         tb, xb, yb, nb;
    logic       eb, er, ed;
    logic [3:0] ee;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Drive one pixel cycle; returns at the following falling edge, after
  // the rising edge has consumed these inputs.
  task automatic cyc(input logic pdr, input logic sdr, input int typ,
                     input int x, input int y, input logic sof);
    player_drawingRequest = pdr;
    step_drawingRequest   = sdr;
    step_type             = 3'(typ);
    player_offsetX        = 11'(x);
    player_offsetY        = 11'(y);
    startOfFrame          = sof;
    @(negedge clk);
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b0);
  endtask

  // Each hit is followed by a near-miss pixel (step not drawing).
  task automatic hits(input int n, input int typ, input int x, input int y);
    for (int i = 0; i < n; i++) begin
      cyc(1'b1, 1'b1, typ, x, y, 1'b0);
      cyc(1'b1, 1'b0, typ, x, y, 1'b0);
    end
  endtask

  task automatic check_out(input string name, input logic b, input logic r,
                           input logic d, input logic [3:0] e);
    check({name, "_brk"},  {3'b0, breaking_step_collision}, {3'b0, b});
    check({name, "_reg"},  {3'b0, regular_step_collision},  {3'b0, r});
    check({name, "_dth"},  {3'b0, death_collision},         {3'b0, d});
    check({name, "_edge"}, HitEdgeCode, e);
  endtask

  task automatic publish_check(input string name, input logic b, input logic r,
                               input logic d, input logic [3:0] e);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    check({name, "_valid"}, {3'b0, verdict_valid}, 4'd1);
    check_out(name, b, r, d, e);
    idle_cyc();
    check({name, "_valid_drop"}, {3'b0, verdict_valid}, 4'd0);
    check_out({name, "_hold"}, b, r, d, e);
  endtask

  initial begin
    logic       pb, pr, pd;
    logic [3:0] pe;

    vecs[0]  = '{"brake_bottom",     6, 10, 30, 6,  0,  0,  0, 0, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[1]  = '{"empty_drop",       0,  0,  0, 0,  0,  0,  0, 0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[2]  = '{"below_min",        1, 10, 30, 1,  0,  0,  0, 0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[3]  = '{"tie_top_left_mix", 1, 10,  1, 3,  5,  1, 16, 3, 1'b0, 1'b1, 1'b1, 4'b0100};
    vecs[4]  = '{"right_wins",       2, 30, 16, 3,  3,  2, 10, 2, 1'b0, 1'b1, 1'b1, 4'b0010};
    vecs[5]  = '{"interior_only",    4, 16, 16, 2,  0,  0,  0, 0, 1'b0, 1'b1, 1'b0, 4'b0001};
    vecs[6]  = '{"free_ignored",     0, 10, 30, 5,  0,  0,  0, 0, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[7]  = '{"out_of_box",       6, 40, 30, 3,  6, 10, 32, 3, 1'b0, 1'b0, 1'b0, 4'b0000};
    vecs[8]  = '{"corner_top",       1, 30,  1, 3,  1, 30, 16, 2, 1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[9]  = '{"left_band",        1,  3, 16, 3,  1,  4, 16, 2, 1'b0, 1'b1, 1'b0, 4'b1000};
    vecs[10] = '{"right_band",       2, 28, 16, 2,  2, 27, 16, 3, 1'b0, 1'b1, 1'b0, 4'b0010};
    vecs[11] = '{"top_band",         4, 16,  3, 2,  4, 16,  4, 3, 1'b0, 1'b1, 1'b0, 4'b0100};
    vecs[12] = '{"bottom_band",      6, 10, 28, 2,  6, 10, 27, 3, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[13] = '{"tie_left_right",   5,  1, 16, 2,  5, 30, 16, 2, 1'b0, 1'b0, 1'b1, 4'b1000};
    vecs[14] = '{"tie_bottom_top",   3, 10, 31, 2,  3, 10,  0, 2, 1'b0, 1'b0, 1'b1, 4'b0001};
    vecs[15] = '{"persist_a",        6, 10, 30, 2,  0,  0,  0, 0, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[16] = '{"persist_b",        6, 10, 30, 2,  0,  0,  0, 0, 1'b1, 1'b0, 1'b0, 4'b0001};
    vecs[17] = '{"persist_drop",     0,  0,  0, 0,  0,  0,  0, 0, 1'b0, 1'b0, 1'b0, 4'b0000};

    // Clock/reset
    resetN                = 1'b0;
    startOfFrame          = 1'b0;
    player_drawingRequest = 1'b0;
    step_drawingRequest   = 1'b0;
    step_type             = 3'd0;
    player_offsetX        = 11'd0;
    player_offsetY        = 11'd0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
    check({4'b0, "reset_valid"} == "" ? "x" : "reset_valid", {3'b0, verdict_valid}, 4'd0);
    check_out("reset", 1'b0, 1'b0, 1'b0, 4'b0000);

    // Hits before the first frame boundary must not count.
    hits(4, 6, 10, 30);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    check("first_sof_no_valid", {3'b0, verdict_valid}, 4'd0);
    check_out("first_sof", 1'b0, 1'b0, 1'b0, 4'b0000);

    pb = 1'b0; pr = 1'b0; pd = 1'b0; pe = 4'b0000;
    for (int i = 0; i < 18; i++) begin
      hits(vecs[i].na, vecs[i].ta, vecs[i].xa, vecs[i].ya);
      hits(vecs[i].nb, vecs[i].tb, vecs[i].xb, vecs[i].yb);
      check_out({vecs[i].name, "_prev_held"}, pb, pr, pd, pe);
      publish_check(vecs[i].name, vecs[i].eb, vecs[i].er, vecs[i].ed, vecs[i].ee);
      pb = vecs[i].eb; pr = vecs[i].er; pd = vecs[i].ed; pe = vecs[i].ee;
    end

    // Hit on the boundary cycle belongs to the new frame.
    cyc(1'b1, 1'b1, 6, 10, 30, 1'b1);
    check("sofhit_valid", {3'b0, verdict_valid}, 4'd1);
    check_out("sofhit_prior", 1'b0, 1'b0, 1'b0, 4'b0000);
    idle_cyc();
    hits(1, 6, 10, 30);
    publish_check("sofhit_next", 1'b1, 1'b0, 1'b0, 4'b0001);

    // startOfFrame while already publishing acts as another publish.
    hits(2, 6, 10, 30);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    check("b2b_first_valid", {3'b0, verdict_valid}, 4'd1);
    check_out("b2b_first", 1'b1, 1'b0, 1'b0, 4'b0001);
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    check("b2b_second_valid", {3'b0, verdict_valid}, 4'd1);
    check_out("b2b_second", 1'b0, 1'b0, 1'b0, 4'b0000);
    idle_cyc();
    check("b2b_valid_drop", {3'b0, verdict_valid}, 4'd0);

    // Bottom counter saturates; a wrapped count would lose to TOP.
    for (int i = 0; i < 1100; i++) cyc(1'b1, 1'b1, 1, 10, 30, 1'b0);
    hits(100, 1, 10, 1);
    publish_check("saturate", 1'b0, 1'b1, 1'b0, 4'b0001);

    // Asynchronous reset mid-frame discards the partial frame.
    hits(5, 6, 10, 30);
    resetN = 1'b0;
    #2;
    check("async_rst_valid", {3'b0, verdict_valid}, 4'd0);
    check_out("async_rst", 1'b0, 1'b0, 1'b0, 4'b0000);
    @(negedge clk);
    resetN = 1'b1;
    cyc(1'b0, 1'b0, 0, 0, 0, 1'b1);
    check("post_rst_sof_valid", {3'b0, verdict_valid}, 4'd0);
    check_out("post_rst_sof", 1'b0, 1'b0, 1'b0, 4'b0000);
    idle_cyc();
    check("post_rst_idle_valid", {3'b0, verdict_valid}, 4'd0);
    hits(2, 6, 10, 30);
    publish_check("post_rst_frame", 1'b1, 1'b0, 1'b0, 4'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
